// File: rtl/hex_entry.sv
// rtl/hex_entry.sv - four-button hex word editor with valid/ready commit
//
// Purpose: edits a 16-bit word one nibble at a time from debounced buttons,
// drives the display source and cursor blink, and hands a committed copy of
// the word to the core over a valid/ready handshake.
//
// Ports:
//   clk     system clock
//   rst     asynchronous reset, active high
//   btn     debounced button levels: [0]=inc [1]=dec [2]=cursor [3]=commit
//   value   word currently being edited
//   cursor  nibble being edited, 0 = bits [3:0]
//   blink   cursor blink phase for digit blanking
//   data    committed word presented to the core
//   valid   data is valid and awaiting acceptance
//   ready   core accepts data when valid & ready at a clk edge

module hex_entry #(
  parameter logic [23:0] REPEAT_DELAY  = 24'd5000000,
  parameter logic [23:0] REPEAT_PERIOD = 24'd1000000,
  parameter logic [23:0] BLINK_HALF    = 24'd4000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  btn,
  output logic [15:0] value,
  output logic [1:0]  cursor,
  output logic        blink,
  output logic [15:0] data,
  output logic        valid,
  input  logic        ready
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PEND = 1'b1
  } state_t;

  state_t      state, state_nx;
  logic        load_data;

  logic [3:0]  btn_q;     // previous button levels
  logic [3:0]  press_q;   // registered rising edges; acts one cycle later
  logic [23:0] rpt;
  logic [23:0] blink_cnt;

  logic        one_held;
  logic        edit_press;
  logic        any_press;
  logic        rpt_fire;
  logic        step_inc;
  logic        step_dec;
  logic [3:0]  nib_idx;
  logic [3:0]  nib;
  logic [3:0]  nib_nx;
  logic [15:0] value_nx;
  logic [23:0] rpt_nx;

  // Edge detection: press_q is registered so edits land two edges after btn
  // rises, leaving the held levels in btn_q aligned with press_q for the
  // repeat counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q   <= 4'd0;
      press_q <= 4'd0;
    end else begin
      btn_q   <= btn;
      press_q <= btn & ~btn_q;
    end
  end

  assign one_held   = btn_q[0] ^ btn_q[1];
  assign edit_press = press_q[0] | press_q[1];
  assign any_press  = |press_q;

  // A repeat step fires only while exactly one of inc/dec is held and no
  // fresh press is being handled this cycle.
  assign rpt_fire = one_held && !edit_press && (rpt == REPEAT_DELAY - 24'd1);
  assign step_inc = press_q[0] | (rpt_fire & btn_q[0]);
  assign step_dec = press_q[1] | (rpt_fire & btn_q[1]);

  // After a step the counter restarts part-way so later steps fall
  // REPEAT_PERIOD cycles apart instead of REPEAT_DELAY.
  always_comb begin
    rpt_nx = rpt + 24'd1;
    if (!one_held || edit_press) begin
      rpt_nx = 24'd0;
    end else if (rpt_fire) begin
      rpt_nx = REPEAT_DELAY - REPEAT_PERIOD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt <= 24'd0;
    end else begin
      rpt <= rpt_nx;
    end
  end

  // Nibble edit at the current (pre-move) cursor; no carry between nibbles,
  // and simultaneous inc/dec cancel.
  assign nib_idx = {cursor, 2'b00};

  always_comb begin
    nib = value[nib_idx +: 4];
    nib_nx = nib;
    case ({step_inc, step_dec})
      2'b10:   nib_nx = nib + 4'd1;
      2'b01:   nib_nx = nib - 4'd1;
      default: nib_nx = nib;
    endcase
    value_nx = value;
    value_nx[nib_idx +: 4] = nib_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value  <= 16'd0;
      cursor <= 2'd0;
    end else begin
      value <= value_nx;
      if (press_q[2]) begin
        cursor <= cursor + 2'd1;
      end
    end
  end

  // Blink restarts in the visible phase on any press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= 24'd0;
      blink     <= 1'b0;
    end else if (any_press) begin
      blink_cnt <= 24'd0;
      blink     <= 1'b0;
    end else if (blink_cnt == BLINK_HALF - 24'd1) begin
      blink_cnt <= 24'd0;
      blink     <= ~blink;
    end else begin
      blink_cnt <= blink_cnt + 24'd1;
    end
  end

  // Commit handshake. data captures value before any same-cycle edit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      data  <= 16'd0;
    end else begin
      state <= state_nx;
      if (load_data) begin
        data <= value;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    load_data = 1'b0;
    case (state)
      S_IDLE: begin
        if (press_q[3]) begin
          load_data = 1'b1;
          state_nx  = S_PEND;
        end
      end
      S_PEND: begin
        if (ready) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign valid = (state == S_PEND);

endmodule
